// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry architectural register file.
// Two combinational read ports with write-through bypass, and a commit counter.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        WBReg,
    input  logic [DATA_W-1:0] MemOpReg,
    input  logic [DATA_W-1:0] ResultRTypeReg,
    input  logic [ADDR_W-1:0] WrRegReg,
    input  logic [ADDR_W-1:0] RdReg1,
    input  logic [ADDR_W-1:0] RdReg2,
    output logic [DATA_W-1:0] RdData1,
    output logic [DATA_W-1:0] RdData2,
    output logic [DATA_W-1:0] WbData,
    output logic              WbEn,
    output logic [CNT_W-1:0]  WrCount
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [CNT_W-1:0]  r_count;

    logic              w_reg_write;
    logic              w_mem_to_reg;
    logic              w_dst_nonzero;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_en;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_reg_write   = WBReg[1];
    assign w_mem_to_reg  = WBReg[0];
    assign w_dst_nonzero = (WrRegReg != '0);

    // Data mux is independent of RegWrite so forwarding always sees a value.
    assign w_wb_data = w_mem_to_reg ? MemOpReg : ResultRTypeReg;
    assign w_wb_en   = w_reg_write & w_dst_nonzero & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else if (w_wb_en) begin
            r_regs[WrRegReg] <= w_wb_data;
            r_count          <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_rd1 = r_regs[RdReg1];
        if (RdReg1 == '0) begin
            w_rd1 = '0;
        end else if (w_wb_en && (RdReg1 == WrRegReg)) begin
            w_rd1 = w_wb_data;
        end
    end

    always_comb begin
        w_rd2 = r_regs[RdReg2];
        if (RdReg2 == '0) begin
            w_rd2 = '0;
        end else if (w_wb_en && (RdReg2 == WrRegReg)) begin
            w_rd2 = w_wb_data;
        end
    end

    assign RdData1 = w_rd1;
    assign RdData2 = w_rd2;
    assign WbData  = w_wb_data;
    assign WbEn    = w_wb_en;
    assign WrCount = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed cases then random traffic,
// checked against an array model; a 4-bit-counter instance covers wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  WBReg;
    logic [31:0] MemOpReg;
    logic [31:0] ResultRTypeReg;
    logic [4:0]  WrRegReg;
    logic [4:0]  RdReg1;
    logic [4:0]  RdReg2;

    logic [31:0] rd1_a, rd2_a, wbd_a, cnt_a;
    logic        en_a;
    logic [31:0] rd1_b, rd2_b, wbd_b;
    logic        en_b;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    wb_regfile u_dut (
        .clk(clk), .reset(reset), .WBReg(WBReg),
        .MemOpReg(MemOpReg), .ResultRTypeReg(ResultRTypeReg),
        .WrRegReg(WrRegReg), .RdReg1(RdReg1), .RdReg2(RdReg2),
        .RdData1(rd1_a), .RdData2(rd2_a), .WbData(wbd_a),
        .WbEn(en_a), .WrCount(cnt_a)
    );

    wb_regfile #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .WBReg(WBReg),
        .MemOpReg(MemOpReg), .ResultRTypeReg(ResultRTypeReg),
        .WrRegReg(WrRegReg), .RdReg1(RdReg1), .RdReg2(RdReg2),
        .RdData1(rd1_b), .RdData2(rd2_b), .WbData(wbd_b),
        .WbEn(en_b), .WrCount(cnt_b)
    );

    typedef struct {
        bit          full;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wbd;
        logic        en;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit running = 1'b0;

    logic [31:0] m_regs [32];
    int unsigned m_cnt;
    bit          m_known = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("WbData", wbd_a, e.wbd);
                chk("WbEn", {31'd0, en_a}, {31'd0, e.en});
                chk("WbData4", wbd_b, e.wbd);
                chk("WbEn4", {31'd0, en_b}, {31'd0, e.en});
                if (e.full) begin
                    chk("RdData1", rd1_a, e.rd1);
                    chk("RdData2", rd2_a, e.rd2);
                    chk("WrCount", cnt_a, e.cnt);
                    chk("RdData1_4", rd1_b, e.rd1);
                    chk("RdData2_4", rd2_b, e.rd2);
                    chk("WrCount4", {28'd0, cnt_b}, {28'd0, e.cnt4});
                end
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] rd, input bit en,
                                           input logic [4:0] wr, input logic [31:0] d);
        if (rd == 5'd0) return 32'd0;
        if (en && rd == wr) return d;
        return m_regs[rd];
    endfunction

    task automatic step(input logic rst, input logic [1:0] wb,
                        input logic [31:0] mem, input logic [31:0] alu,
                        input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        logic [31:0] d;
        bit en;
        reset = rst; WBReg = wb; MemOpReg = mem; ResultRTypeReg = alu;
        WrRegReg = wr; RdReg1 = r1; RdReg2 = r2;
        d  = wb[0] ? mem : alu;
        en = wb[1] && (wr != 5'd0) && !rst;
        e.full = m_known;
        e.wbd  = d;
        e.en   = en;
        e.rd1  = m_read(r1, en, wr, d);
        e.rd2  = m_read(r2, en, wr, d);
        e.cnt  = m_cnt;
        e.cnt4 = 4'(m_cnt % 16);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt   = 0;
            m_known = 1'b1;
        end else if (en) begin
            m_regs[wr] = d;
            m_cnt      = m_cnt + 1;
        end
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, 2'b00, $urandom, $urandom, 5'($urandom), r1, r2);
    endtask

    initial begin
        bit prev_rst;
        m_cnt = 0;
        reset = 1'b1; WBReg = 2'b00; MemOpReg = '0; ResultRTypeReg = '0;
        WrRegReg = '0; RdReg1 = '0; RdReg2 = '0;
        #1;
        running = 1'b1;

        step(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd5, 5'd7);
        step(1'b0, 2'b10, 32'd0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd7);
        rd(5'd5, 5'd7);
        step(1'b1, 2'b10, 32'd0, 32'h1111_2222, 5'd7, 5'd5, 5'd7);
        step(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd5, 5'd7);

        step(1'b0, 2'b10, 32'hFFFF_0000, 32'h0000_1234, 5'd3, 5'd4, 5'd0);
        rd(5'd3, 5'd0);
        step(1'b0, 2'b11, 32'hFFFF_0000, 32'h0000_1234, 5'd3, 5'd4, 5'd0);
        rd(5'd3, 5'd3);
        step(1'b0, 2'b01, 32'hCAFE_F00D, 32'h0000_5678, 5'd3, 5'd3, 5'd3);

        step(1'b0, 2'b00, 32'd0, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);
        step(1'b0, 2'b10, 32'd0, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);
        step(1'b0, 2'b00, 32'd0, 32'h5A5A_5A5A, 5'd9, 5'd9, 5'd9);

        step(1'b0, 2'b10, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        rd(5'd0, 5'd9);

        step(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 2'b10, 32'd0, 32'd1, 5'd1, 5'd1, 5'd2);
        step(1'b0, 2'b10, 32'd0, 32'd2, 5'd2, 5'd1, 5'd2);
        step(1'b0, 2'b10, 32'd0, 32'd3, 5'd1, 5'd1, 5'd2);
        for (int i = 0; i < 16; i++) rd(5'(2 * i), 5'(2 * i + 1));

        step(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 2'b11, $urandom, $urandom, 5'(1 + (i % 31)), 5'(i), 5'(i + 1));
        end
        rd(5'd1, 5'd17);

        prev_rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic [4:0] w, a, b;
            logic [1:0] c;
            bit r;
            w = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            a = ($urandom_range(2) == 0) ? w : 5'($urandom);
            b = ($urandom_range(2) == 0) ? w : 5'($urandom);
            c = prev_rst ? 2'b00 : 2'($urandom);
            r = ($urandom_range(49) == 0);
            step(r, c, $urandom, $urandom, w, a, b);
            prev_rst = r;
        end

        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
